mem_wb_pipe_reg: RTL and testbench
==================================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Elastic MEM->WB pipeline register for the pipelined core; generalised in XLEN, field widths and buffering depth.
//  Carries reg_write, result_src, alu_result, rdata, rd and pc_plus4 under a valid/ready handshake with synchronous flush.
//  SKID=1 adds a second entry so ready_o is a pure flop output, breaking the WB->MEM ready timing path.
// PARAMETERS
//  XLEN        32  data/address width of alu_result, rdata, pc_plus4
//  REG_ADDR_W  5   register-file index width (rd)
//  RES_SRC_W   2   result-select field width
//  SKID        1   0: single entry, ready_o combinational; 1: two-entry skid buffer, ready_o registered
// PORTS
//  clk            in   1           clock, rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  flush_i        in   1           synchronous flush; kills all held and incoming entries
//  valid_i        in   1           MEM-side payload valid
//  ready_o        out  1           stage can accept a payload this cycle
//  reg_write_i    in   1           MEM register-write enable
//  result_src_i   in   RES_SRC_W   MEM result select
//  alu_result_i   in   XLEN        MEM ALU result
//  rdata_i        in   XLEN        MEM load data
//  rd_i           in   REG_ADDR_W  MEM destination register
//  pc_plus4_i     in   XLEN        MEM PC+4
//  valid_o        out  1           WB-side payload valid
//  ready_i        in   1           WB consumes the payload this cycle
//  reg_write_o    out  1           qualified write enable = valid_o & held reg_write & (rd_o != 0)
//  result_src_o   out  RES_SRC_W   held result select
//  alu_result_o   out  XLEN        held ALU result
//  rdata_o        out  XLEN        held load data
//  rd_o           out  REG_ADDR_W  held destination register (captured from rd_i)
//  pc_plus4_o     out  XLEN        held PC+4
//  occupancy_o    out  2           entries held: 0..1 (SKID=0), 0..2 (SKID=1)
// BEHAVIOUR
//  - Reset (async, rst_n=0): all valid flags 0, all payload flops 0. Outputs: valid_o=0, reg_write_o=0, payload outputs 0,
//    occupancy_o=0, ready_o=1. The same values hold on the first edge after rst_n deasserts.
//  - Handshake: accept = valid_i & ready_o; drain = valid_o & ready_i. Once asserted, valid_o and payload stay stable until drain.
//  - Latency: an accepted payload appears on the outputs on the next rising edge with valid_o=1 (1 cycle). No bubble on back-to-back transfers.
//  - SKID=0: one entry (main). ready_o = ~main_v | ready_i, combinational.
//    On accept, main loads the input and main_v=1. On drain with no accept, main_v=0.
//  - SKID=1: main and skid entries. ready_o = ~skid_v, registered; never depends on ready_i in the same cycle.
//    - accept & (~main_v | drain): input goes to main.
//    - accept & main_v & ~drain: input goes to skid; skid_v=1; ready_o drops on the next cycle.
//    - drain & skid_v: skid moves to main; skid_v=0. Any accept in that cycle is impossible because ready_o=0.
//    - Order is strictly FIFO; the main entry always drives the outputs.
//  - occupancy_o = main_v + skid_v.
//  - Flush: on a flush_i=1 edge, all valid flags are cleared and any same-cycle accept is discarded.
//    Payload flops hold their values; outputs are gated only via valid_o and reg_write_o.
//    flush_i has priority over accept, drain and transfer. ready_o=1 on the next cycle.
//  - reg_write_o is low whenever valid_o=0 or rd_o=0, so x0 is never written.
//  - valid_i=0 with ready_o=1: no state change; payload inputs are don't-care.
//  - A drain is counted even when valid_i=0 in the same cycle.
//  - Reset asserted mid-transfer: state is cleared immediately (async), independent of clk.
// TESTING
//  1 Reset: rst_n=0 mid-stream with main+skid full -> valid_o=0, occupancy_o=0, ready_o=1 with no clk edge; payload outputs 0.
//  2 Pass-through, ready_i=1: 4 back-to-back payloads, rd=1..4, alu=0x10..0x13 -> outputs 1 cycle later, one per cycle, no bubbles.
//  3 Backpressure (SKID=1): ready_i=0, send A(rd=5), B(rd=6) -> occupancy 2, ready_o=0, rd_o=5 held.
//    Then ready_i=1 -> rd_o=5, then 6, then valid_o=0.
//  4 SKID=0 backpressure: ready_i=0 with main full -> ready_o=0 in the same cycle; ready_i=1 & valid_i=1 -> simultaneous drain+accept, occupancy stays 1.
//  5 Flush with occupancy 2 and valid_i=1 -> next cycle valid_o=0, occupancy 0, ready_o=1; the flushed input never appears.
//  6 x0 guard: reg_write_i=1, rd_i=0, alu=0xDEADBEEF -> valid_o=1, reg_write_o=0. Same with rd_i=7 -> reg_write_o=1.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB elastic pipeline register with valid/ready handshake and synchronous flush.
// SKID=1 adds a second entry so ready_o comes straight from a flop instead of following ready_i.
module mem_wb_pipe_reg #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned RES_SRC_W  = 2,
    parameter int unsigned SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  reg_write_i,
    input  logic [RES_SRC_W-1:0]  result_src_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic [XLEN-1:0]       rdata_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [XLEN-1:0]       pc_plus4_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  reg_write_o,
    output logic [RES_SRC_W-1:0]  result_src_o,
    output logic [XLEN-1:0]       alu_result_o,
    output logic [XLEN-1:0]       rdata_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [XLEN-1:0]       pc_plus4_o,
    output logic [1:0]            occupancy_o
);

    typedef struct packed {
        logic                  reg_write;
        logic [RES_SRC_W-1:0]  result_src;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       rdata;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       pc_plus4;
    } payload_t;

    payload_t in_pl;
    payload_t main_q, main_d;
    payload_t skid_q, skid_d;
    logic     main_v_q, main_v_d;
    logic     skid_v_q, skid_v_d;
    logic     ready_q, ready_d;
    logic     accept;
    logic     drain;

    assign in_pl = '{reg_write:  reg_write_i,
                     result_src: result_src_i,
                     alu_result: alu_result_i,
                     rdata:      rdata_i,
                     rd:         rd_i,
                     pc_plus4:   pc_plus4_i};

    // With a skid entry ready_o is a flop; without it, a full entry can still accept while draining.
    assign ready_o = (SKID != 0) ? ready_q : (~main_v_q | ready_i);
    assign accept  = valid_i & ready_o;
    assign drain   = main_v_q & ready_i;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush_i) begin
            // Flush drops only the valid flags; payload flops keep their contents.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (SKID == 0) begin
            if (accept) begin
                main_d   = in_pl;
                main_v_d = 1'b1;
            end else if (drain) begin
                main_v_d = 1'b0;
            end
        end else begin
            if (drain && skid_v_q) begin
                // ready_o is low while skid is full, so no accept can collide with this move.
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept && (!main_v_q || drain)) begin
                main_d   = in_pl;
                main_v_d = 1'b1;
            end else if (accept) begin
                skid_d   = in_pl;
                skid_v_d = 1'b1;
            end else if (drain) begin
                main_v_d = 1'b0;
            end
        end
        ready_d = ~skid_v_d;
    end

    // NOTE: payload flops are reset as well so outputs read 0 out of reset, not just invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    assign valid_o      = main_v_q;
    assign reg_write_o  = main_v_q & main_q.reg_write & (|main_q.rd);
    assign result_src_o = main_q.result_src;
    assign alu_result_o = main_q.alu_result;
    assign rdata_o      = main_q.rdata;
    assign rd_o         = main_q.rd;
    assign pc_plus4_o   = main_q.pc_plus4;
    assign occupancy_o  = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: a SKID=1 instance for most cases and a SKID=0 instance
// for the combinational-ready behaviour; both share the same stimulus.
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        valid_i;
    logic        ready_i;
    logic        reg_write_i;
    logic [1:0]  result_src_i;
    logic [31:0] alu_result_i;
    logic [31:0] rdata_i;
    logic [4:0]  rd_i;
    logic [31:0] pc_plus4_i;

    logic        ready_o,  valid_o,  reg_write_o;
    logic [1:0]  result_src_o, occupancy_o;
    logic [31:0] alu_result_o, rdata_o, pc_plus4_o;
    logic [4:0]  rd_o;

    logic        ready0_o, valid0_o, reg_write0_o;
    logic [1:0]  result_src0_o, occupancy0_o;
    logic [31:0] alu_result0_o, rdata0_o, pc_plus40_o;
    logic [4:0]  rd0_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.XLEN(32), .REG_ADDR_W(5), .RES_SRC_W(2), .SKID(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .reg_write_i(reg_write_i), .result_src_i(result_src_i), .alu_result_i(alu_result_i),
        .rdata_i(rdata_i), .rd_i(rd_i), .pc_plus4_i(pc_plus4_i), .valid_o(valid_o),
        .ready_i(ready_i), .reg_write_o(reg_write_o), .result_src_o(result_src_o),
        .alu_result_o(alu_result_o), .rdata_o(rdata_o), .rd_o(rd_o), .pc_plus4_o(pc_plus4_o),
        .occupancy_o(occupancy_o)
    );

    mem_wb_pipe_reg #(.XLEN(32), .REG_ADDR_W(5), .RES_SRC_W(2), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready0_o),
        .reg_write_i(reg_write_i), .result_src_i(result_src_i), .alu_result_i(alu_result_i),
        .rdata_i(rdata_i), .rd_i(rd_i), .pc_plus4_i(pc_plus4_i), .valid_o(valid0_o),
        .ready_i(ready_i), .reg_write_o(reg_write0_o), .result_src_o(result_src0_o),
        .alu_result_o(alu_result0_o), .rdata_o(rdata0_o), .rd_o(rd0_o), .pc_plus4_o(pc_plus40_o),
        .occupancy_o(occupancy0_o)
    );

    typedef struct {
        logic        v;
        logic        rdy;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic        e_v;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic [1:0]  e_occ;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Payload fields other than rd/alu are derived from them so every field is traceable.
    task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] alu);
        valid_i      = v;
        reg_write_i  = rw;
        rd_i         = rd;
        result_src_i = rd[1:0];
        alu_result_i = alu;
        rdata_i      = alu ^ 32'hFFFF_0000;
        pc_plus4_i   = alu + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);

        // Power-on reset values, then the same values one edge after release
        #12;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_occ", {30'b0, occupancy_o}, 32'd0);
        check("rst_alu", alu_result_o, 32'd0);
        check("rst_rw", {31'b0, reg_write_o}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        step();
        check("post_rst_valid", {31'b0, valid_o}, 32'd0);
        check("post_rst_ready", {31'b0, ready_o}, 32'd1);
        check("post_rst_rd", {27'b0, rd_o}, 32'd0);

        // Pass-through (rows 0..4) and SKID=1 backpressure (rows 5..9)
        vecs[0] = '{1'b1, 1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h10, 2'd1, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 32'h11, 2'd1, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 5'd3, 32'h12, 1'b1, 5'd3, 32'h12, 2'd1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 5'd4, 32'h13, 1'b1, 5'd4, 32'h13, 2'd1, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 5'd0, 32'h00, 1'b0, 5'd4, 32'h13, 2'd0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 5'd5, 32'h20, 1'b1, 5'd5, 32'h20, 2'd1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 5'd6, 32'h21, 1'b1, 5'd5, 32'h20, 2'd2, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 5'd7, 32'h22, 1'b1, 5'd5, 32'h20, 2'd2, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 5'd0, 32'h00, 1'b1, 5'd6, 32'h21, 2'd1, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 5'd0, 32'h00, 1'b0, 5'd6, 32'h21, 2'd0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, 1'b1, vecs[i].rd, vecs[i].alu);
            ready_i = vecs[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i), {31'b0, valid_o}, {31'b0, vecs[i].e_v});
            check($sformatf("vec%0d_rd", i), {27'b0, rd_o}, {27'b0, vecs[i].e_rd});
            check($sformatf("vec%0d_alu", i), alu_result_o, vecs[i].e_alu);
            check($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].e_alu ^ 32'hFFFF_0000);
            check($sformatf("vec%0d_pc4", i), pc_plus4_o, vecs[i].e_alu + 32'd4);
            check($sformatf("vec%0d_rsrc", i), {30'b0, result_src_o}, {30'b0, vecs[i].e_rd[1:0]});
            check($sformatf("vec%0d_occ", i), {30'b0, occupancy_o}, {30'b0, vecs[i].e_occ});
            check($sformatf("vec%0d_ready", i), {31'b0, ready_o}, {31'b0, vecs[i].e_rdy});
        end

        // Flush with two entries held and a valid input in the same cycle
        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd8, 32'h30);
        step();
        drive(1'b1, 1'b1, 5'd9, 32'h31);
        step();
        check("pre_flush_occ", {30'b0, occupancy_o}, 32'd2);
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 5'd10, 32'h32);
        step();
        flush_i = 1'b0;
        check("flush_valid", {31'b0, valid_o}, 32'd0);
        check("flush_occ", {30'b0, occupancy_o}, 32'd0);
        check("flush_ready", {31'b0, ready_o}, 32'd1);
        check("flush_rw", {31'b0, reg_write_o}, 32'd0);
        check("flush_rd_held", {27'b0, rd_o}, 32'd8);
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        ready_i = 1'b1;
        step();
        check("flush_no_ghost_valid", {31'b0, valid_o}, 32'd0);
        check("flush_no_ghost_occ", {30'b0, occupancy_o}, 32'd0);

        // x0 write guard, then a real destination with simultaneous drain+accept
        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        step();
        check("x0_valid", {31'b0, valid_o}, 32'd1);
        check("x0_rw", {31'b0, reg_write_o}, 32'd0);
        check("x0_alu", alu_result_o, 32'hDEAD_BEEF);
        ready_i = 1'b1;
        drive(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        step();
        check("rd7_valid", {31'b0, valid_o}, 32'd1);
        check("rd7_rd", {27'b0, rd_o}, 32'd7);
        check("rd7_rw", {31'b0, reg_write_o}, 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        step();
        check("rd7_drained_rw", {31'b0, reg_write_o}, 32'd0);

        // SKID=0: ready_o follows ready_i combinationally when the entry is full
        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd11, 32'h40);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        check("s0_full_valid", {31'b0, valid0_o}, 32'd1);
        check("s0_full_occ", {30'b0, occupancy0_o}, 32'd1);
        check("s0_ready_low", {31'b0, ready0_o}, 32'd0);
        ready_i = 1'b1;
        #1;
        check("s0_ready_comb", {31'b0, ready0_o}, 32'd1);
        check("s1_ready_not_comb", {31'b0, ready_o}, 32'd1);
        drive(1'b1, 1'b1, 5'd12, 32'h41);
        step();
        check("s0_swap_valid", {31'b0, valid0_o}, 32'd1);
        check("s0_swap_occ", {30'b0, occupancy0_o}, 32'd1);
        check("s0_swap_rd", {27'b0, rd0_o}, 32'd12);
        check("s0_swap_alu", alu_result0_o, 32'h41);
        check("s0_swap_rdata", rdata0_o, 32'h41 ^ 32'hFFFF_0000);
        check("s0_swap_pc4", pc_plus40_o, 32'h45);
        check("s0_swap_rsrc", {30'b0, result_src0_o}, 32'd0);
        check("s0_swap_rw", {31'b0, reg_write0_o}, 32'd1);

        // Asynchronous reset with both SKID=1 entries full, no clock edge involved
        ready_i = 1'b0;
        drive(1'b1, 1'b1, 5'd13, 32'h50);
        step();
        drive(1'b1, 1'b1, 5'd14, 32'h51);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        check("pre_rst_occ", {30'b0, occupancy_o}, 32'd2);
        check("pre_rst_ready", {31'b0, ready_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, valid_o}, 32'd0);
        check("async_rst_occ", {30'b0, occupancy_o}, 32'd0);
        check("async_rst_ready", {31'b0, ready_o}, 32'd1);
        check("async_rst_rd", {27'b0, rd_o}, 32'd0);
        check("async_rst_alu", alu_result_o, 32'd0);
        check("async_rst_s0_valid", {31'b0, valid0_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("async_rst_hold_valid", {31'b0, valid_o}, 32'd0);
        check("async_rst_hold_ready", {31'b0, ready_o}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
